// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared execute-stage widths, shift mode encoding and helpers
package exec_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        MODE_NONE = 2'd0,
        MODE_SHL  = 2'd1,
        MODE_SHR  = 2'd2,
        MODE_SAR  = 2'd3
    } shift_mode_e;

    // Left wins over right, right over arithmetic right.
    function automatic shift_mode_e decode_mode(input logic left, input logic right,
                                                input logic math_shift);
        if (left)            return MODE_SHL;
        else if (right)      return MODE_SHR;
        else if (math_shift) return MODE_SAR;
        else                 return MODE_NONE;
    endfunction

    function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] value);
        logic [XLEN-1:0] rev;
        for (int i = 0; i < XLEN; i++) begin
            rev[i] = value[XLEN-1-i];
        end
        return rev;
    endfunction

endpackage

// File: rtl/barrel_shr32.sv
// rtl/barrel_shr32.sv - combinational 5-stage log right shifter with last-bit-out
module barrel_shr32
    import exec_pkg::*;
(
    input  logic [XLEN-1:0]    data,
    input  logic [SHAMT_W-1:0] sh,
    input  logic               fill,
    output logic [XLEN-1:0]    shifted,
    output logic               last_out
);

    logic [SHAMT_W:0][XLEN-1:0] stage;
    logic [SHAMT_W:0]           carry;

    assign stage[0] = data;
    assign carry[0] = 1'b0;

    // The bit leaving an enabled stage is original data[partial_shift-1]; the last enabled stage wins.
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int N = 1 << k;
        assign stage[k+1] = sh[k] ? {{N{fill}}, stage[k][XLEN-1:N]} : stage[k];
        assign carry[k+1] = sh[k] ? stage[k][N-1] : carry[k];
    end

    assign shifted  = stage[SHAMT_W];
    assign last_out = carry[SHAMT_W];

endmodule

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - registered 32-bit shifter (sll/srl/sra) with carry-out flag
module shift_unit
    import exec_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [XLEN-1:0] src,
    input  logic [XLEN-1:0] dst,
    input  logic            left,
    input  logic            right,
    input  logic            math_shift,
    output logic [XLEN-1:0] result,
    output logic            cf,
    output logic            out_valid
);

    shift_mode_e        mode;
    logic [SHAMT_W-1:0] sh;
    logic [XLEN-1:0]    core_in;
    logic [XLEN-1:0]    core_out;
    logic               core_fill;
    logic               core_last;
    logic [XLEN-1:0]    next_result;
    logic               next_cf;
    logic               unused_src_bits;

    assign mode            = decode_mode(left, right, math_shift);
    assign sh              = src[SHAMT_W-1:0];
    assign unused_src_bits = ^src[XLEN-1:SHAMT_W];

    // Left shifts reuse the right-shift core on the mirrored word.
    assign core_in   = (mode == MODE_SHL) ? bit_reverse(dst) : dst;
    assign core_fill = (mode == MODE_SAR) & dst[XLEN-1];

    barrel_shr32 u_core (
        .data     (core_in),
        .sh       (sh),
        .fill     (core_fill),
        .shifted  (core_out),
        .last_out (core_last)
    );

    always_comb begin
        next_result = core_out;
        next_cf     = core_last;
        case (mode)
            MODE_NONE: begin
                next_result = dst;
                next_cf     = 1'b0;
            end
            MODE_SHL:  next_result = bit_reverse(core_out);
            default:   next_result = core_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            cf        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result <= next_result;
                cf     <= next_cf;
            end
        end
    end

endmodule

// File: tb/tb_shift_unit.sv
// tb/tb_shift_unit.sv - self-checking bench for shift_unit: vector table, random model, reset
module tb_shift_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] src;
    logic [31:0] dst;
    logic        left;
    logic        right;
    logic        math_shift;
    logic [31:0] result;
    logic        cf;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_result;
    logic        exp_cf;

    always #5 clk = ~clk;

    shift_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .src        (src),
        .dst        (dst),
        .left       (left),
        .right      (right),
        .math_shift (math_shift),
        .result     (result),
        .cf         (cf),
        .out_valid  (out_valid)
    );

    typedef struct {
        string       name;
        logic [31:0] src;
        logic [31:0] dst;
        logic        left;
        logic        right;
        logic        math_shift;
        logic [31:0] exp_result;
        logic        exp_cf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference: place the word in a 64-bit window so the bit just past the result is the carry.
    task automatic ref_shift(input logic [31:0] s, input logic [31:0] d, input logic l,
                             input logic r, input logic m,
                             output logic [31:0] res, output logic c);
        int          n;
        logic [63:0] w;
        n = int'(s % 32);
        if (l) begin
            w   = {32'd0, d} << n;
            res = w[31:0];
            c   = w[32];
        end else if (r) begin
            w   = {d, 32'd0} >> n;
            res = w[63:32];
            c   = w[31];
        end else if (m) begin
            w   = $signed({d, 32'd0}) >>> n;
            res = w[63:32];
            c   = w[31];
        end else begin
            res = d;
            c   = 1'b0;
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] s, input logic [31:0] d,
                         input logic l, input logic r, input logic m);
        @(negedge clk);
        in_valid   = v;
        src        = s;
        dst        = d;
        left       = l;
        right      = r;
        math_shift = m;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"shl_1",      32'd1,         32'h80000003, 1, 0, 0, 32'h00000006, 1'b1});
        vecs.push_back('{"shl_0",      32'd0,         32'h80000003, 1, 0, 0, 32'h80000003, 1'b0});
        vecs.push_back('{"shr_2",      32'd2,         32'h80000003, 0, 1, 0, 32'h20000000, 1'b1});
        vecs.push_back('{"shr_31",     32'd31,        32'h80000003, 0, 1, 0, 32'h00000001, 1'b0});
        vecs.push_back('{"sar_4",      32'd4,         32'h80000000, 0, 0, 1, 32'hF8000000, 1'b0});
        vecs.push_back('{"sar_31",     32'd31,        32'h7FFFFFFF, 0, 0, 1, 32'h00000000, 1'b1});
        vecs.push_back('{"prio_lr",    32'hFFFFFFE1,  32'd3,        1, 1, 0, 32'h00000006, 1'b0});
        vecs.push_back('{"prio_rm",    32'd1,         32'h80000001, 0, 1, 1, 32'h40000000, 1'b1});
        vecs.push_back('{"none",       32'd5,         32'h00001234, 0, 0, 0, 32'h00001234, 1'b0});
        vecs.push_back('{"shl_31",     32'd31,        32'h00000003, 1, 0, 0, 32'h80000000, 1'b1});
        vecs.push_back('{"sar_0",      32'd0,         32'h80000001, 0, 0, 1, 32'h80000001, 1'b0});

        rst_n = 1'b0; in_valid = 1'b1; src = $urandom; dst = $urandom;
        left = 1'b1; right = 1'b0; math_shift = 1'b0;
        repeat (3) begin
            @(negedge clk);
            src = $urandom; dst = $urandom;
        end
        check("rst_result", result, 32'd0);
        check("rst_cf", {31'd0, cf}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);

        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_result", result, 32'd0);
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);

        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].src, vecs[i].dst, vecs[i].left, vecs[i].right, vecs[i].math_shift);
            check({vecs[i].name, "_result"}, result, vecs[i].exp_result);
            check({vecs[i].name, "_cf"}, {31'd0, cf}, {31'd0, vecs[i].exp_cf});
            check({vecs[i].name, "_valid"}, {31'd0, out_valid}, 32'd1);
        end

        // Idle cycle: outputs hold, out_valid drops.
        exp_result = vecs[vecs.size()-1].exp_result;
        exp_cf     = vecs[vecs.size()-1].exp_cf;
        drive(1'b0, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
        check("idle_hold_result", result, exp_result);
        check("idle_hold_cf", {31'd0, cf}, {31'd0, exp_cf});
        check("idle_valid", {31'd0, out_valid}, 32'd0);

        for (int mode = 0; mode < 3; mode++) begin
            for (int k = 0; k < 100; k++) begin
                logic [31:0] s;
                logic [31:0] d;
                logic        l;
                logic        r;
                logic        m;
                logic [31:0] er;
                logic        ec;
                s = $urandom; d = $urandom;
                l = (mode == 0); r = (mode == 1); m = (mode == 2);
                ref_shift(s, d, l, r, m, er, ec);
                drive(1'b1, s, d, l, r, m);
                check($sformatf("rand_m%0d_%0d_result", mode, k), result, er);
                check($sformatf("rand_m%0d_%0d_cf", mode, k), {31'd0, cf}, {31'd0, ec});
                check($sformatf("rand_m%0d_%0d_valid", mode, k), {31'd0, out_valid}, 32'd1);
            end
        end

        // Sporadic in_valid: valid follows one cycle later, results hold across gaps.
        ref_shift(src, dst, left, right, math_shift, exp_result, exp_cf);
        for (int k = 0; k < 60; k++) begin
            logic        v;
            logic [31:0] s;
            logic [31:0] d;
            logic [2:0]  strobes;
            logic [31:0] er;
            logic        ec;
            v = 1'($urandom_range(0, 1));
            s = $urandom; d = $urandom;
            strobes = 3'($urandom);
            ref_shift(s, d, strobes[2], strobes[1], strobes[0], er, ec);
            drive(v, s, d, strobes[2], strobes[1], strobes[0]);
            if (v) begin
                exp_result = er;
                exp_cf     = ec;
            end
            check($sformatf("mix_%0d_result", k), result, exp_result);
            check($sformatf("mix_%0d_cf", k), {31'd0, cf}, {31'd0, exp_cf});
            check($sformatf("mix_%0d_valid", k), {31'd0, out_valid}, {31'd0, v});
        end

        // Mid-stream asynchronous reset clears immediately, between clock edges.
        drive(1'b1, 32'd1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        check("pre_midrst_result", result, 32'hFFFFFFFE);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_result", result, 32'd0);
        check("midrst_cf", {31'd0, cf}, 32'd0);
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'd4, 32'h80000000, 1'b0, 1'b0, 1'b1);
        check("after_midrst_result", result, 32'hF8000000);
        check("after_midrst_valid", {31'd0, out_valid}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
